// File: rtl/vga_pkg.sv
// Shared constants for the rectangle-fill engine: screen geometry, register map,
// control/status bit positions and the fill FSM state encoding.
package vga_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int X_MAX = SCR_W - 1;
    localparam int Y_MAX = SCR_H - 1;

    localparam logic [7:0] BASE_ADDR = 8'hB4;

    localparam logic [2:0] OFF_X0   = 3'd0;
    localparam logic [2:0] OFF_Y0   = 3'd1;
    localparam logic [2:0] OFF_X1   = 3'd2;
    localparam logic [2:0] OFF_Y1   = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;
    localparam logic [2:0] OFF_STAT = 3'd5;

    localparam int CTRL_COL     = 0;
    localparam int CTRL_START   = 1;
    localparam int CTRL_IRQ_CLR = 2;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    function automatic logic [7:0] clip(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vga_fill_ctrl_if.sv
// Frame buffer port A: the direct pixel request path and the arbitrated write port.
interface vga_fill_ctrl_if;
    logic [14:0] PIX_ADDR;
    logic        PIX_DATA;
    logic        PIX_WE;
    logic        PIX_GNT;
    logic [14:0] FB_ADDR;
    logic        FB_DATA;
    logic        FB_WE;

    modport master (output PIX_ADDR, PIX_DATA, PIX_WE,
                    input  PIX_GNT, FB_ADDR, FB_DATA, FB_WE);
    modport slave  (input  PIX_ADDR, PIX_DATA, PIX_WE,
                    output PIX_GNT, FB_ADDR, FB_DATA, FB_WE);
endinterface

// File: rtl/vga_fill_regs.sv
// Processor bus decode for the fill engine: corner/colour registers, registered
// tristate read-back and the START / IRQ_CLR write pulses.
module vga_fill_regs
    import vga_pkg::*;
#(
    parameter logic [7:0] BaseAddr = BASE_ADDR
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic       busy,
    input  logic       done_irq,
    output logic [7:0] x0,
    output logic [7:0] x1,
    output logic [6:0] y0,
    output logic [6:0] y1,
    output logic       colour,
    output logic       start,
    output logic       irq_clr
);

    logic [7:0] offs;
    logic       in_range;
    logic       wr;
    logic [7:0] rd_mux;
    logic [7:0] rd_q;
    logic       rd_oe;

    // Unsigned subtract folds the lower and upper bound checks into one compare.
    assign offs     = BUS_ADDR - BaseAddr;
    assign in_range = (offs <= 8'd5);
    assign wr       = BUS_WE && in_range;
    assign start    = wr && (offs[2:0] == OFF_CTRL) && BUS_DATA[CTRL_START];
    assign irq_clr  = wr && (offs[2:0] == OFF_CTRL) && BUS_DATA[CTRL_IRQ_CLR];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x0     <= '0;
            y0     <= '0;
            x1     <= '0;
            y1     <= '0;
            colour <= 1'b0;
        end else if (wr) begin
            case (offs[2:0])
                OFF_X0:   x0     <= BUS_DATA;
                OFF_Y0:   y0     <= BUS_DATA[6:0];
                OFF_X1:   x1     <= BUS_DATA;
                OFF_Y1:   y1     <= BUS_DATA[6:0];
                OFF_CTRL: colour <= BUS_DATA[CTRL_COL];
                default:  ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (offs[2:0])
            OFF_X0:   rd_mux = x0;
            OFF_Y0:   rd_mux = {1'b0, y0};
            OFF_X1:   rd_mux = x1;
            OFF_Y1:   rd_mux = {1'b0, y1};
            OFF_CTRL: rd_mux[CTRL_COL] = colour;
            OFF_STAT: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done_irq;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_oe <= 1'b0;
            rd_q  <= '0;
        end else begin
            rd_oe <= in_range && !BUS_WE;
            rd_q  <= rd_mux;
        end
    end

    assign BUS_DATA = rd_oe ? rd_q : 8'bz;

endmodule

// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill engine and port A write arbiter: the direct pixel path owns the
// port while idle, the raster-scan fill owns it from SETUP through DONE.
module vga_fill_ctrl
    import vga_pkg::*;
#(
    parameter logic [7:0] BaseAddr = BASE_ADDR,
    parameter int         XMax     = X_MAX,
    parameter int         YMax     = Y_MAX
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    vga_fill_ctrl_if.slave port_a,
    output logic       BUSY,
    output logic       DONE_IRQ
);

    state_t     state, state_nx;
    logic [7:0] x0, x1, xa, xb, xl, xh, cx;
    logic [6:0] y0, y1, ya, yb, yl, yh, cy;
    logic       colour, fcol, start, irq_clr, done_q, last;

    vga_fill_regs #(.BaseAddr(BaseAddr)) u_regs (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUS_DATA (BUS_DATA),
        .BUS_ADDR (BUS_ADDR),
        .BUS_WE   (BUS_WE),
        .busy     (BUSY),
        .done_irq (done_q),
        .x0       (x0),
        .x1       (x1),
        .y0       (y0),
        .y1       (y1),
        .colour   (colour),
        .start    (start),
        .irq_clr  (irq_clr)
    );

    assign xa   = clip(x0, 8'(XMax));
    assign xb   = clip(x1, 8'(XMax));
    assign ya   = 7'(clip({1'b0, y0}, 8'(YMax)));
    assign yb   = 7'(clip({1'b0, y1}, 8'(YMax)));
    assign last = (cx == xh) && (cy == yh);

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SETUP;
            SETUP:   state_nx = FILL;
            FILL:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Scan counters run on latched bounds so register rewrites mid-fill are harmless.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            xl   <= '0;
            xh   <= '0;
            yl   <= '0;
            yh   <= '0;
            cx   <= '0;
            cy   <= '0;
            fcol <= 1'b0;
        end else if (state == SETUP) begin
            xl   <= (xa < xb) ? xa : xb;
            xh   <= (xa < xb) ? xb : xa;
            yl   <= (ya < yb) ? ya : yb;
            yh   <= (ya < yb) ? yb : ya;
            cx   <= (xa < xb) ? xa : xb;
            cy   <= (ya < yb) ? ya : yb;
            fcol <= colour;
        end else if (state == FILL) begin
            if (cx == xh) begin
                cx <= xl;
                cy <= cy + 7'd1;
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

    // Completion sets the sticky flag even if a clear lands on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET)                done_q <= 1'b0;
        else if (state == DONE)   done_q <= 1'b1;
        else if (irq_clr)         done_q <= 1'b0;
    end

    assign DONE_IRQ = done_q;

    always_comb begin
        BUSY           = (state != IDLE);
        port_a.PIX_GNT = (state == IDLE);
        port_a.FB_ADDR = port_a.PIX_ADDR;
        port_a.FB_DATA = port_a.PIX_DATA;
        port_a.FB_WE   = port_a.PIX_WE;
        if (state != IDLE) begin
            port_a.FB_ADDR = {cy, cx};
            port_a.FB_DATA = fcol;
            port_a.FB_WE   = (state == FILL);
        end
    end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Directed bench for vga_fill_ctrl: reset abort, raster fills, clipping, IRQ
// handling, arbitration and bus read-back/tristate.
module tb_vga_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic       drv = 1'b0;
    logic [7:0] dval = 8'h00;
    wire  [7:0] bus_data;
    logic       busy, done_irq;
    logic [7:0] rd;
    logic [14:0] e2 [0:5];
    logic [14:0] e4 [0:7];
    int n_cmp = 0;
    int n_mis = 0;

    assign bus_data = drv ? dval : 8'bz;

    // Released bus floats to all-ones so a stray driver is visible.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    vga_fill_ctrl_if pa();

    vga_fill_ctrl dut (
        .CLK      (clk),
        .RESET    (rst),
        .BUS_DATA (bus_data),
        .BUS_ADDR (bus_addr),
        .BUS_WE   (bus_we),
        .port_a   (pa),
        .BUSY     (busy),
        .DONE_IRQ (done_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; dval = d; drv = 1'b1; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; drv = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_addr = a; bus_we = 1'b0;
        @(negedge clk);
        d = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic rect(input logic [7:0] x0, input logic [7:0] y0,
                        input logic [7:0] x1, input logic [7:0] y1, input logic [7:0] ctrl);
        bus_wr(8'hB4, x0);
        bus_wr(8'hB5, y0);
        bus_wr(8'hB6, x1);
        bus_wr(8'hB7, y1);
        bus_wr(8'hB8, ctrl);
    endtask

    initial begin
        e2 = '{15'h0203, 15'h0204, 15'h0205, 15'h0303, 15'h0304, 15'h0305};
        e4 = '{15'h0001, 15'h0002, 15'h0003, 15'h0004,
               15'h0101, 15'h0102, 15'h0103, 15'h0104};
        pa.PIX_ADDR = '0; pa.PIX_DATA = 1'b0; pa.PIX_WE = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_fb_we", pa.FB_WE, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_irq", done_irq, 1'b0);
        chk("rst_gnt", pa.PIX_GNT, 1'b1);
        chk("rst_bus_z", bus_data, 8'hFF);
        rst = 1'b0;

        // reset mid-fill
        rect(8'd0, 8'd0, 8'd9, 8'd0, 8'h03);
        chk("abort_setup_busy", busy, 1'b1);
        @(negedge clk);
        chk("abort_px0", pa.FB_ADDR, 15'h0000);
        @(negedge clk);
        @(negedge clk);
        chk("abort_px2_we", pa.FB_WE, 1'b1);
        chk("abort_px2", pa.FB_ADDR, 15'h0002);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we", pa.FB_WE, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_gnt", pa.PIX_GNT, 1'b1);
        rst = 1'b0;
        bus_rd(8'hB9, rd);
        chk("abort_status", rd, 8'h00);
        pa.PIX_WE = 1'b1; pa.PIX_ADDR = 15'h0102; pa.PIX_DATA = 1'b1;
        #1;
        chk("pass_we", pa.FB_WE, 1'b1);
        chk("pass_addr", pa.FB_ADDR, 15'h0102);
        chk("pass_data", pa.FB_DATA, 1'b1);
        pa.PIX_WE = 1'b0;

        // reversed corners, pixel requests held during the fill
        rect(8'd5, 8'd3, 8'd3, 8'd2, 8'h03);
        pa.PIX_WE = 1'b1; pa.PIX_ADDR = 15'h0102; pa.PIX_DATA = 1'b0;
        #1;
        chk("f2_setup_we", pa.FB_WE, 1'b0);
        chk("f2_setup_gnt", pa.PIX_GNT, 1'b0);
        chk("f2_setup_busy", busy, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("f2_we", pa.FB_WE, 1'b1);
            chk("f2_addr", pa.FB_ADDR, e2[i]);
            chk("f2_data", pa.FB_DATA, 1'b1);
            chk("f2_gnt", pa.PIX_GNT, 1'b0);
        end
        @(negedge clk);
        chk("f2_done_we", pa.FB_WE, 1'b0);
        chk("f2_done_busy", busy, 1'b1);
        chk("f2_done_irq0", done_irq, 1'b0);
        @(negedge clk);
        chk("f2_idle_busy", busy, 1'b0);
        chk("f2_idle_irq", done_irq, 1'b1);
        chk("f2_idle_pass", pa.FB_ADDR, 15'h0102);
        chk("f2_idle_pass_we", pa.FB_WE, 1'b1);
        pa.PIX_WE = 1'b0;
        bus_rd(8'hB9, rd);
        chk("f2_status", rd, 8'h02);

        // clipping, 1x1 fill, IRQ clear and set-wins
        bus_wr(8'hB8, 8'h04);
        chk("irq_clr", done_irq, 1'b0);
        rect(8'd200, 8'd127, 8'd200, 8'd127, 8'h02);
        @(negedge clk);
        chk("clip_we", pa.FB_WE, 1'b1);
        chk("clip_addr", pa.FB_ADDR, 15'h779F);
        chk("clip_data", pa.FB_DATA, 1'b0);
        @(negedge clk);
        chk("clip_one_write", pa.FB_WE, 1'b0);
        chk("clip_done_busy", busy, 1'b1);
        bus_addr = 8'hB8; dval = 8'h06; drv = 1'b1; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; drv = 1'b0; bus_addr = 8'h00;
        chk("set_wins_irq", done_irq, 1'b1);
        chk("set_wins_busy", busy, 1'b0);
        @(negedge clk);
        chk("no_restart_busy", busy, 1'b0);

        // START and X0 rewrite while busy
        bus_wr(8'hB8, 8'h04);
        rect(8'd1, 8'd0, 8'd4, 8'd1, 8'h03);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("f4_we", pa.FB_WE, 1'b1);
            chk("f4_addr", pa.FB_ADDR, e4[i]);
            if (i == 2) begin
                bus_addr = 8'hB4; dval = 8'h00; drv = 1'b1; bus_we = 1'b1;
            end else if (i == 3) begin
                bus_addr = 8'hB8; dval = 8'h03;
            end else if (i == 4) begin
                bus_we = 1'b0; drv = 1'b0; bus_addr = 8'h00;
            end
        end
        @(negedge clk);
        chk("f4_done_we", pa.FB_WE, 1'b0);
        chk("f4_done_irq0", done_irq, 1'b0);
        @(negedge clk);
        chk("f4_irq", done_irq, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("f4_no_restart", busy, 1'b0);
            chk("f4_no_write", pa.FB_WE, 1'b0);
        end

        // bus decode and read-back
        bus_rd(8'hB3, rd);
        chk("rd_B3_z", rd, 8'hFF);
        bus_rd(8'hBA, rd);
        chk("rd_BA_z", rd, 8'hFF);
        bus_wr(8'hB6, 8'h9F);
        bus_rd(8'hB6, rd);
        chk("rd_X1", rd, 8'h9F);
        bus_rd(8'hB8, rd);
        chk("rd_CTRL", rd, 8'h01);
        bus_rd(8'hB4, rd);
        chk("rd_X0", rd, 8'h00);
        bus_rd(8'hB7, rd);
        chk("rd_Y1", rd, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
